medidor_eco: RTL

Measurement front end for an HC-SR04-class ultrasonic sensor. On request, it generates the trigger pulse and times the echo pulse. It converts the echo width to an integer distance in centimetres and presents it as a W-bit binary value with a one-cycle `pronto` strobe. It sits directly upstream of `bin2bcd`: `distancia` drives `binary`, and `pronto` drives `start`, so no edge detector is needed between them.

---
 rtl/medidor_eco.sv | 121 ++++++++++++
 1 files changed

// File: rtl/medidor_eco.sv
// Ultrasonic ranging front end: issues the sensor trigger, times the echo and
// reports the distance in whole centimetres with a one-cycle pronto strobe.
module medidor_eco #(
  parameter int W              = 7,
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_CYCLES      = 2941,
  parameter int TIMEOUT_CYCLES = 1_500_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         medir,
  input  logic         echo,
  output logic         trigger,
  output logic [W-1:0] distancia,
  output logic         pronto,
  output logic         erro,
  output logic [3:0]   db_estado
);

  localparam int MAXC = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int TW   = $clog2(CM_CYCLES + 1);

  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] TOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CM_CYCLES - 1);
  localparam logic [W-1:0]  CM_MAX    = {W{1'b1}};

  localparam logic [3:0] S_INICIAL  = 4'd0;
  localparam logic [3:0] S_TRIGGER  = 4'd1;
  localparam logic [3:0] S_ESPERA   = 4'd2;
  localparam logic [3:0] S_MEDE     = 4'd3;
  localparam logic [3:0] S_ARMAZENA = 4'd4;
  localparam logic [3:0] S_FINAL    = 4'd5;
  localparam logic [3:0] S_ERRO     = 4'd7;

  logic          r_echoMeta, r_echoSync;
  logic [3:0]    r_state, w_next;
  logic [CW-1:0] r_cnt, w_cntNext;
  logic [TW-1:0] r_tick, w_tickNext;
  logic [W-1:0]  r_cm, w_cmNext;
  logic [W-1:0]  r_dist;
  logic          r_trigger, r_pronto, r_erro;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INICIAL:  if (medir) w_next = S_TRIGGER;
      S_TRIGGER:  if (r_cnt == TRIG_LAST) w_next = S_ESPERA;
      S_ESPERA: begin
        if (r_echoSync)              w_next = S_MEDE;
        else if (r_cnt == TOUT_LAST) w_next = S_ERRO;
      end
      S_MEDE: begin
        if (!r_echoSync)             w_next = S_ARMAZENA;
        else if (r_cnt == TOUT_LAST) w_next = S_ERRO;
      end
      S_ARMAZENA: w_next = S_FINAL;
      S_FINAL:    w_next = medir ? S_TRIGGER : S_INICIAL;
      S_ERRO:     if (medir) w_next = S_TRIGGER;
      default:    w_next = S_INICIAL;
    endcase
  end

  // The cycle that sees echo rise in ESPERA is the first measured sample, so
  // entering MEDE already counts one; this keeps N equal to the raw width.
  always_comb begin
    w_tickNext = '0;
    w_cmNext   = '0;
    if (w_next != r_state) begin
      w_cntNext = (w_next == S_MEDE) ? CW'(1) : '0;
    end else if (r_state == S_TRIGGER || r_state == S_ESPERA || r_state == S_MEDE) begin
      w_cntNext = r_cnt + 1'b1;
    end else begin
      w_cntNext = '0;
    end
    if (w_next == S_MEDE) begin
      if (r_tick == TICK_LAST) begin
        w_cmNext = (r_cm == CM_MAX) ? r_cm : r_cm + 1'b1;
      end else begin
        w_tickNext = r_tick + 1'b1;
        w_cmNext   = r_cm;
      end
    end else if (w_next == S_ARMAZENA) begin
      w_cmNext = r_cm;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_echoMeta <= 1'b0;
      r_echoSync <= 1'b0;
      r_state    <= S_INICIAL;
      r_cnt      <= '0;
      r_tick     <= '0;
      r_cm       <= '0;
      r_dist     <= '0;
      r_trigger  <= 1'b0;
      r_pronto   <= 1'b0;
      r_erro     <= 1'b0;
    end else begin
      r_echoMeta <= echo;
      r_echoSync <= r_echoMeta;
      r_state    <= w_next;
      r_cnt      <= w_cntNext;
      r_tick     <= w_tickNext;
      r_cm       <= w_cmNext;
      r_trigger  <= (w_next == S_TRIGGER);
      r_pronto   <= (w_next == S_FINAL);
      r_erro     <= (w_next == S_ERRO);
      if (r_state == S_ARMAZENA) r_dist <= r_cm;
    end
  end

  assign trigger   = r_trigger;
  assign distancia = r_dist;
  assign pronto    = r_pronto;
  assign erro      = r_erro;
  assign db_estado = r_state;

endmodule
